// File: rtl/tl_rx_fc_credit_tracker.sv
// -----------------------------------------------------------------------------
// tl_rx_fc_credit_tracker
//
// Receive-side flow-control credit bookkeeping for the TL RX write handler.
// Per class (P / NP / CPL) it keeps header and data CREDITS_RECEIVED and
// CREDITS_ALLOCATED counters. These counters feed the receiver-overflow
// checker that sits directly downstream. It also raises per-class UpdateFC
// requests towards the DLL whenever buffer space is returned.
//
// Handshake: both input sides are valid-only. Each cycle with i_rcv_valid
// (or i_rel_valid) high carries exactly one TLP. There is no back-pressure.
// Class encoding 2'b11 means "no TLP", and such a cycle is ignored.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   i_rcv_*                      TLP accepted by RX (class, payload, length, drop)
//   i_rel_*                      TLP storage freed from the RX buffer
//   i_fc_update_ack[2:0]         {CPL,NP,P} DLL has sent UpdateFC
//   o_chk_en/typ/len             same-cycle overflow-check request to checker
//   o_{p,np,cpl}_rcv_hdr/data    CREDITS_RECEIVED counters
//   o_{p,np,cpl}_alloc_hdr/data  CREDITS_ALLOCATED counters
//   o_fc_update_req[2:0]         {CPL,NP,P} UpdateFC pending (per-class FSM state)
// -----------------------------------------------------------------------------
module tl_rx_fc_credit_tracker #(
   parameter int HDR_FIELD_SIZE  = 8,
   parameter int DATA_FIELD_SIZE = 12,
   parameter int PAYLOAD_LENGTH  = 10,
   parameter int P_HDR_INIT      = 32,
   parameter int NP_HDR_INIT     = 32,
   parameter int CPL_HDR_INIT    = 32,
   parameter int P_DATA_INIT     = 256,
   parameter int NP_DATA_INIT    = 16,
   parameter int CPL_DATA_INIT   = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_rcv_valid,
   input  logic [1:0]                 i_rcv_typ,
   input  logic                       i_rcv_has_data,
   input  logic [PAYLOAD_LENGTH-1:0]  i_rcv_len,
   input  logic                       i_rcv_drop,
   input  logic                       i_rel_valid,
   input  logic [1:0]                 i_rel_typ,
   input  logic                       i_rel_has_data,
   input  logic [PAYLOAD_LENGTH-1:0]  i_rel_len,
   input  logic [2:0]                 i_fc_update_ack,
   output logic                       o_chk_en,
   output logic [1:0]                 o_chk_typ,
   output logic [PAYLOAD_LENGTH-1:0]  o_chk_len,
   output logic [HDR_FIELD_SIZE-1:0]  o_p_rcv_hdr,
   output logic [DATA_FIELD_SIZE-1:0] o_p_rcv_data,
   output logic [HDR_FIELD_SIZE-1:0]  o_np_rcv_hdr,
   output logic [DATA_FIELD_SIZE-1:0] o_np_rcv_data,
   output logic [HDR_FIELD_SIZE-1:0]  o_cpl_rcv_hdr,
   output logic [DATA_FIELD_SIZE-1:0] o_cpl_rcv_data,
   output logic [HDR_FIELD_SIZE-1:0]  o_p_alloc_hdr,
   output logic [DATA_FIELD_SIZE-1:0] o_p_alloc_data,
   output logic [HDR_FIELD_SIZE-1:0]  o_np_alloc_hdr,
   output logic [DATA_FIELD_SIZE-1:0] o_np_alloc_data,
   output logic [HDR_FIELD_SIZE-1:0]  o_cpl_alloc_hdr,
   output logic [DATA_FIELD_SIZE-1:0] o_cpl_alloc_data,
   output logic [2:0]                 o_fc_update_req
);

   localparam logic [1:0] TYP_NONE = 2'b11;

   localparam logic [HDR_FIELD_SIZE-1:0] HDR_INIT [3] = '{
      HDR_FIELD_SIZE'(P_HDR_INIT), HDR_FIELD_SIZE'(NP_HDR_INIT), HDR_FIELD_SIZE'(CPL_HDR_INIT)};
   localparam logic [DATA_FIELD_SIZE-1:0] DATA_INIT [3] = '{
      DATA_FIELD_SIZE'(P_DATA_INIT), DATA_FIELD_SIZE'(NP_DATA_INIT), DATA_FIELD_SIZE'(CPL_DATA_INIT)};

   // Per-class UpdateFC request flag. The state is the o_fc_update_req bit.
   typedef enum logic {
      REQ_IDLE    = 1'b0,
      REQ_PENDING = 1'b1
   } req_state_e;

   // Data credits are 4-DW units. A length of 0 encodes 1024 DW, which is 256 credits.
   // The sum is one bit wider than the length field, so (len+3) cannot overflow.
   function automatic logic [8:0] tlp_data_credits(input logic                      has_data,
                                                   input logic [PAYLOAD_LENGTH-1:0] len);
      logic [PAYLOAD_LENGTH:0] sum;
      sum = {1'b0, len} + (PAYLOAD_LENGTH+1)'(3);
      if (!has_data)
         return 9'd0;
      else if (len == '0)
         return 9'd256;
      else
         return 9'(sum >> 2);
   endfunction

   logic                       chk_en;
   logic [8:0]                 rcv_cred;
   logic [8:0]                 rel_cred;
   logic [DATA_FIELD_SIZE-1:0] rcv_cred_ext;
   logic [DATA_FIELD_SIZE-1:0] rel_cred_ext;
   logic [2:0]                 rcv_hit;
   logic [2:0]                 rel_hit;

   logic [HDR_FIELD_SIZE-1:0]  rcv_hdr_q    [3];
   logic [DATA_FIELD_SIZE-1:0] rcv_data_q   [3];
   logic [HDR_FIELD_SIZE-1:0]  alloc_hdr_q  [3];
   logic [DATA_FIELD_SIZE-1:0] alloc_data_q [3];

   req_state_e req_q [3];
   req_state_e req_d [3];

   // Decode which class, if any, each side touches this cycle. Class 2'b11 never
   // matches an index 0..2, so "no TLP" falls out of the compare automatically.
   always_comb begin
      chk_en       = i_rcv_valid & (i_rcv_typ != TYP_NONE);
      rcv_cred     = tlp_data_credits(i_rcv_has_data, i_rcv_len);
      rel_cred     = tlp_data_credits(i_rel_has_data, i_rel_len);
      rcv_cred_ext = DATA_FIELD_SIZE'(rcv_cred);
      rel_cred_ext = DATA_FIELD_SIZE'(rel_cred);
      rcv_hit      = '0;
      rel_hit      = '0;
      for (int c = 0; c < 3; c++) begin
         rcv_hit[c] = chk_en & ~i_rcv_drop & (i_rcv_typ == 2'(c));
         rel_hit[c] = i_rel_valid & (i_rel_typ == 2'(c));
      end
   end

   // The checker compares against the counters as they stand this cycle (pre-increment).
   assign o_chk_en  = chk_en;
   assign o_chk_typ = i_rcv_typ;
   assign o_chk_len = i_rcv_has_data ? i_rcv_len : '0;

   // Credit counters. All adds wrap modulo the field width by construction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) begin
            rcv_hdr_q[c]    <= '0;
            rcv_data_q[c]   <= '0;
            alloc_hdr_q[c]  <= HDR_INIT[c];
            alloc_data_q[c] <= DATA_INIT[c];
         end
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (rcv_hit[c]) begin
               rcv_hdr_q[c]  <= rcv_hdr_q[c] + HDR_FIELD_SIZE'(1);
               rcv_data_q[c] <= rcv_data_q[c] + rcv_cred_ext;
            end
            if (rel_hit[c]) begin
               alloc_hdr_q[c]  <= alloc_hdr_q[c] + HDR_FIELD_SIZE'(1);
               alloc_data_q[c] <= alloc_data_q[c] + rel_cred_ext;
            end
         end
      end
   end

   // UpdateFC request FSMs: state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) req_q[c] <= REQ_IDLE;
      end else begin
         for (int c = 0; c < 3; c++) req_q[c] <= req_d[c];
      end
   end

   // UpdateFC request FSMs: next state. A release in the same cycle as an ack
   // keeps the request pending, because the credits it frees are not yet advertised.
   always_comb begin
      o_fc_update_req = '0;
      for (int c = 0; c < 3; c++) begin
         req_d[c] = req_q[c];
         case (req_q[c])
            REQ_IDLE:    if (rel_hit[c]) req_d[c] = REQ_PENDING;
            REQ_PENDING: if (i_fc_update_ack[c] && !rel_hit[c]) req_d[c] = REQ_IDLE;
         endcase
         o_fc_update_req[c] = (req_q[c] == REQ_PENDING);
      end
   end

   assign o_p_rcv_hdr      = rcv_hdr_q[0];
   assign o_p_rcv_data     = rcv_data_q[0];
   assign o_np_rcv_hdr     = rcv_hdr_q[1];
   assign o_np_rcv_data    = rcv_data_q[1];
   assign o_cpl_rcv_hdr    = rcv_hdr_q[2];
   assign o_cpl_rcv_data   = rcv_data_q[2];
   assign o_p_alloc_hdr    = alloc_hdr_q[0];
   assign o_p_alloc_data   = alloc_data_q[0];
   assign o_np_alloc_hdr   = alloc_hdr_q[1];
   assign o_np_alloc_data  = alloc_data_q[1];
   assign o_cpl_alloc_hdr  = alloc_hdr_q[2];
   assign o_cpl_alloc_data = alloc_data_q[2];

endmodule

// File: tb/tb_tl_rx_fc_credit_tracker.sv
// -----------------------------------------------------------------------------
// tb_tl_rx_fc_credit_tracker
//
// Each driven cycle pushes one expected snapshot of the DUT outputs. The
// snapshot holds the combinational checker outputs for that cycle plus the
// counter and request state produced by earlier edges. A monitor on the
// falling edge pops each snapshot and compares it with the DUT outputs.
// Data credits per TLP are hand-computed and passed in with each vector.
// -----------------------------------------------------------------------------
module tb_tl_rx_fc_credit_tracker;

   localparam int HW = 8;
   localparam int DW = 12;
   localparam int LW = 10;
   localparam logic [1:0] P = 2'd0, NP = 2'd1, CPL = 2'd2, NONE = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic          rcv_valid, rcv_has_data, rcv_drop;
   logic [1:0]    rcv_typ;
   logic [LW-1:0] rcv_len;
   logic          rel_valid, rel_has_data;
   logic [1:0]    rel_typ;
   logic [LW-1:0] rel_len;
   logic [2:0]    fc_ack;
   logic          chk_en;
   logic [1:0]    chk_typ;
   logic [LW-1:0] chk_len;
   logic [HW-1:0] p_rh, np_rh, cpl_rh, p_ah, np_ah, cpl_ah;
   logic [DW-1:0] p_rd, np_rd, cpl_rd, p_ad, np_ad, cpl_ad;
   logic [2:0]    fc_req;

   tl_rx_fc_credit_tracker dut (
      .clk(clk), .rst_n(rst_n),
      .i_rcv_valid(rcv_valid), .i_rcv_typ(rcv_typ), .i_rcv_has_data(rcv_has_data),
      .i_rcv_len(rcv_len), .i_rcv_drop(rcv_drop),
      .i_rel_valid(rel_valid), .i_rel_typ(rel_typ), .i_rel_has_data(rel_has_data),
      .i_rel_len(rel_len), .i_fc_update_ack(fc_ack),
      .o_chk_en(chk_en), .o_chk_typ(chk_typ), .o_chk_len(chk_len),
      .o_p_rcv_hdr(p_rh), .o_p_rcv_data(p_rd), .o_np_rcv_hdr(np_rh), .o_np_rcv_data(np_rd),
      .o_cpl_rcv_hdr(cpl_rh), .o_cpl_rcv_data(cpl_rd),
      .o_p_alloc_hdr(p_ah), .o_p_alloc_data(p_ad), .o_np_alloc_hdr(np_ah), .o_np_alloc_data(np_ad),
      .o_cpl_alloc_hdr(cpl_ah), .o_cpl_alloc_data(cpl_ad),
      .o_fc_update_req(fc_req)
   );

   logic [2:0][HW-1:0] act_rh, act_ah;
   logic [2:0][DW-1:0] act_rd, act_ad;
   assign act_rh = {cpl_rh, np_rh, p_rh};
   assign act_rd = {cpl_rd, np_rd, p_rd};
   assign act_ah = {cpl_ah, np_ah, p_ah};
   assign act_ad = {cpl_ad, np_ad, p_ad};

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic               chk_en;
      logic [1:0]         chk_typ;
      logic [LW-1:0]      chk_len;
      logic [2:0][HW-1:0] rcv_hdr;
      logic [2:0][DW-1:0] rcv_data;
      logic [2:0][HW-1:0] alloc_hdr;
      logic [2:0][DW-1:0] alloc_data;
      logic [2:0]         req;
   } snap_t;

   snap_t exp_q[$];

   // Expected-state model, stepped with hand-computed credit values.
   logic [HW-1:0] m_rh [3];
   logic [DW-1:0] m_rd [3];
   logic [HW-1:0] m_ah [3];
   logic [DW-1:0] m_ad [3];
   logic [2:0]    m_req;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_rh  = '{8'd0, 8'd0, 8'd0};
      m_rd  = '{12'd0, 12'd0, 12'd0};
      m_ah  = '{8'd32, 8'd32, 8'd32};
      m_ad  = '{12'd256, 12'd16, 12'd256};
      m_req = 3'b000;
   endtask

   task automatic push_exp(input logic en, input logic [1:0] typ, input logic [LW-1:0] len);
      snap_t s;
      s.chk_en  = en;
      s.chk_typ = typ;
      s.chk_len = len;
      for (int c = 0; c < 3; c++) begin
         s.rcv_hdr[c]    = m_rh[c];
         s.rcv_data[c]   = m_rd[c];
         s.alloc_hdr[c]  = m_ah[c];
         s.alloc_data[c] = m_ad[c];
      end
      s.req = m_req;
      exp_q.push_back(s);
   endtask

   // ---------------- driver tasks ----------------
   // Drives one cycle, records what should be visible during it, then steps the
   // model for the edge that closes the cycle.
   task automatic cycle(input logic rv, input logic [1:0] rt, input logic rh, input logic [LW-1:0] rl,
                        input logic rd, input logic [8:0] rc,
                        input logic lv, input logic [1:0] lt, input logic lh, input logic [LW-1:0] ll,
                        input logic [8:0] lc, input logic [2:0] ack);
      @(posedge clk);
      #1;
      rcv_valid = rv; rcv_typ = rt; rcv_has_data = rh; rcv_len = rl; rcv_drop = rd;
      rel_valid = lv; rel_typ = lt; rel_has_data = lh; rel_len = ll; fc_ack = ack;
      push_exp(rv && (rt != NONE), rt, rh ? rl : '0);
      if (rv && (rt != NONE) && !rd) begin
         m_rh[rt] = m_rh[rt] + 8'd1;
         m_rd[rt] = m_rd[rt] + DW'(rc);
      end
      m_req = m_req & ~ack;
      if (lv && (lt != NONE)) begin
         m_ah[lt]  = m_ah[lt] + 8'd1;
         m_ad[lt]  = m_ad[lt] + DW'(lc);
         m_req[lt] = 1'b1;
      end
   endtask

   task automatic rcv(input logic [1:0] t, input logic h, input logic [LW-1:0] l, input logic d,
                      input logic [8:0] cred);
      cycle(1'b1, t, h, l, d, cred, 1'b0, P, 1'b0, '0, 9'd0, 3'b000);
   endtask

   task automatic rel(input logic [1:0] t, input logic h, input logic [LW-1:0] l, input logic [8:0] cred,
                      input logic [2:0] ack);
      cycle(1'b0, P, 1'b0, '0, 1'b0, 9'd0, 1'b1, t, h, l, cred, ack);
   endtask

   task automatic idle(input logic [2:0] ack);
      cycle(1'b0, P, 1'b0, '0, 1'b0, 9'd0, 1'b0, P, 1'b0, '0, 9'd0, ack);
   endtask

   // Asserts reset away from the clock edge so the check at the next falling
   // edge sees the asynchronous effect before any rising edge.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      rcv_valid = 1'b0; rcv_typ = P; rcv_has_data = 1'b0; rcv_len = '0; rcv_drop = 1'b0;
      rel_valid = 1'b0; rel_typ = P; rel_has_data = 1'b0; rel_len = '0; fc_ack = 3'b000;
      model_reset();
      push_exp(1'b0, P, '0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      snap_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("chk_en", int'(chk_en), int'(e.chk_en));
         check("chk_typ", int'(chk_typ), int'(e.chk_typ));
         check("chk_len", int'(chk_len), int'(e.chk_len));
         for (int c = 0; c < 3; c++) begin
            check($sformatf("rcv_hdr[%0d]", c), int'(act_rh[c]), int'(e.rcv_hdr[c]));
            check($sformatf("rcv_data[%0d]", c), int'(act_rd[c]), int'(e.rcv_data[c]));
            check($sformatf("alloc_hdr[%0d]", c), int'(act_ah[c]), int'(e.alloc_hdr[c]));
            check($sformatf("alloc_data[%0d]", c), int'(act_ad[c]), int'(e.alloc_data[c]));
         end
         check("fc_update_req", int'(fc_req), int'(e.req));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rcv_valid = 1'b0; rcv_typ = P; rcv_has_data = 1'b0; rcv_len = '0; rcv_drop = 1'b0;
      rel_valid = 1'b0; rel_typ = P; rel_has_data = 1'b0; rel_len = '0; fc_ack = 3'b000;
      model_reset();
      do_reset();

      // P receives: len 16 -> 4, len 0 -> 256, len 1023 -> 256, len 1 -> 1, no data -> 0
      rcv(P, 1'b1, 10'd16, 1'b0, 9'd4);
      rcv(P, 1'b1, 10'd0, 1'b0, 9'd256);
      rcv(P, 1'b1, 10'd1023, 1'b0, 9'd256);
      rcv(P, 1'b1, 10'd1, 1'b0, 9'd1);
      rcv(P, 1'b0, 10'd7, 1'b0, 9'd0);
      idle(3'b000);

      // Dropped NP, class-none receive and release, then a real NP receive (len 4 -> 1)
      rcv(NP, 1'b1, 10'd8, 1'b1, 9'd2);
      rcv(NONE, 1'b1, 10'd8, 1'b0, 9'd2);
      cycle(1'b0, P, 1'b0, '0, 1'b0, 9'd0, 1'b1, NONE, 1'b1, 10'd4, 9'd1, 3'b000);
      rcv(NP, 1'b1, 10'd4, 1'b0, 9'd1);
      idle(3'b000);

      // Same-cycle receive and release: same class (len 5 -> 2), then different classes
      cycle(1'b1, CPL, 1'b1, 10'd5, 1'b0, 9'd2, 1'b1, CPL, 1'b1, 10'd5, 9'd2, 3'b000);
      cycle(1'b1, P, 1'b1, 10'd3, 1'b0, 9'd1, 1'b1, NP, 1'b1, 10'd8, 9'd2, 3'b000);
      idle(3'b000);

      // Release with same-cycle ack keeps the request; a lone ack clears it
      rel(P, 1'b0, 10'd0, 9'd0, 3'b001);
      idle(3'b001);
      idle(3'b110);
      idle(3'b001);
      idle(3'b000);

      // Reset while counters are non-zero and a request is pending
      rel(P, 1'b1, 10'd4, 9'd1, 3'b000);
      rcv(CPL, 1'b1, 10'd9, 1'b0, 9'd3);
      idle(3'b000);
      do_reset();

      // Wrap: 256 header-only P receives, then 16 x 1024 DW
      for (int i = 0; i < 256; i++) rcv(P, 1'b0, 10'd0, 1'b0, 9'd0);
      for (int i = 0; i < 16; i++) rcv(P, 1'b1, 10'd0, 1'b0, 9'd256);
      idle(3'b000);
      idle(3'b000);

      @(negedge clk);
      @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
